// File: rtl/accel_dma_ctrl_pkg.sv
// Shared constants for the accelerator result DMA controller.
// Register map, CTRL/STATUS bit positions and FSM states.
package accel_dma_ctrl_pkg;

  localparam logic [7:0] REG_CTRL   = 8'h00;
  localparam logic [7:0] REG_DST    = 8'h04;
  localparam logic [7:0] REG_LEN    = 8'h08;
  localparam logic [7:0] REG_STATUS = 8'h0C;
  localparam logic [7:0] REG_COUNT  = 8'h10;

  localparam int CTRL_START  = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int CTRL_ABORT  = 2;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_ABORTED = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_WRITE  = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

endpackage

// File: rtl/accel_dma_ctrl.sv
// Moves result words from a show-ahead FIFO into SoC RAM.
// CPU-programmed destination/length, one beat per word.
module accel_dma_ctrl
  import accel_dma_ctrl_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [7:0]  s_addr,
  input  logic [3:0]  s_wstrb,
  input  logic [31:0] s_wdata,
  output logic [31:0] s_rdata,
  input  logic [31:0] fifo_rdata,
  input  logic        fifo_empty,
  output logic        fifo_pop,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  output logic        irq
);

  state_t           r_state;
  logic             r_s_ready;
  logic [31:0]      r_s_rdata;
  logic [31:0]      r_dst;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_len_act;
  logic [LEN_W-1:0] r_count;
  logic [31:0]      r_addr;
  logic [31:0]      r_buf;
  logic             r_irq_en;
  logic             r_busy;
  logic             r_done;
  logic             r_aborted;
  logic             r_abort_pend;

  logic             w_wr;
  logic             w_wr_ctrl;
  logic             w_start;
  logic             w_abort;
  logic [LEN_W-1:0] w_cnt_nxt;
  logic [31:0]      w_rdata;

  // Writes commit on the cycle s_ready is high.
  assign w_wr      = s_valid && r_s_ready && (s_wstrb != 4'h0);
  assign w_wr_ctrl = w_wr && (s_addr == REG_CTRL);
  assign w_abort   = w_wr_ctrl && s_wdata[CTRL_ABORT];
  assign w_start   = w_wr_ctrl && s_wdata[CTRL_START]
                     && !s_wdata[CTRL_ABORT];
  assign w_cnt_nxt = r_count + LEN_W'(1);

  assign s_ready  = r_s_ready;
  assign s_rdata  = r_s_rdata;
  assign fifo_pop = (r_state == ST_WAIT) && !fifo_empty && !w_abort;
  assign m_valid  = (r_state == ST_WRITE);
  assign m_addr   = r_addr;
  assign m_wdata  = r_buf;
  assign m_wstrb  = m_valid ? 4'hF : 4'h0;
  assign irq      = r_done && r_irq_en;

  always_comb begin
    w_rdata = '0;
    case (s_addr)
      REG_CTRL:   w_rdata[CTRL_IRQ_EN] = r_irq_en;
      REG_DST:    w_rdata = r_dst;
      REG_LEN:    w_rdata = 32'(r_len);
      REG_STATUS: w_rdata = {29'd0, r_aborted, r_done, r_busy};
      REG_COUNT:  w_rdata = 32'(r_count);
      default:    w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_s_ready    <= 1'b0;
      r_s_rdata    <= '0;
      r_dst        <= '0;
      r_len        <= '0;
      r_len_act    <= '0;
      r_count      <= '0;
      r_addr       <= '0;
      r_buf        <= '0;
      r_irq_en     <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_aborted    <= 1'b0;
      r_abort_pend <= 1'b0;
    end else begin
      r_s_ready <= s_valid && !r_s_ready;
      r_s_rdata <= (s_valid && !r_s_ready) ? w_rdata : '0;

      if (w_wr && s_addr == REG_DST) r_dst <= {s_wdata[31:2], 2'b00};
      if (w_wr && s_addr == REG_LEN) r_len <= s_wdata[LEN_W-1:0];
      if (w_wr_ctrl) r_irq_en <= s_wdata[CTRL_IRQ_EN];
      if (w_wr && s_addr == REG_STATUS) begin
        if (s_wdata[STAT_DONE])    r_done    <= 1'b0;
        if (s_wdata[STAT_ABORTED]) r_aborted <= 1'b0;
      end

      // FSM status updates below win over a same-cycle W1C.
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            if (r_len != '0) begin
              r_addr    <= r_dst;
              r_count   <= '0;
              r_len_act <= r_len;
              r_busy    <= 1'b1;
              r_state   <= ST_WAIT;
            end else begin
              r_state <= ST_FINISH;
            end
          end
        end
        ST_WAIT: begin
          if (w_abort) begin
            r_aborted <= 1'b1;
            r_busy    <= 1'b0;
            r_state   <= ST_IDLE;
          end else if (!fifo_empty) begin
            r_buf   <= fifo_rdata;
            r_state <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (w_abort) r_abort_pend <= 1'b1;
          if (m_ready) begin
            r_count <= w_cnt_nxt;
            r_addr  <= r_addr + 32'd4;
            if (w_abort || r_abort_pend) begin
              r_abort_pend <= 1'b0;
              r_aborted    <= 1'b1;
              r_busy       <= 1'b0;
              r_state      <= ST_IDLE;
            end else if (w_cnt_nxt == r_len_act) begin
              r_state <= ST_FINISH;
            end else begin
              r_state <= ST_WAIT;
            end
          end
        end
        ST_FINISH: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_accel_dma_ctrl.sv
// Self-checking bench: FIFO/RAM model plus directed and random transfers.
// Beats are checked against expected address/word streams every cycle.
module tb_accel_dma_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [7:0]  s_addr = '0;
  logic [3:0]  s_wstrb = '0;
  logic [31:0] s_wdata = '0;
  logic [31:0] s_rdata;
  logic [31:0] fifo_rdata = '0;
  logic        fifo_empty = 1'b1;
  logic        fifo_pop;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        irq;

  accel_dma_ctrl #(.LEN_W(16)) dut (
    .clk(clk), .reset(reset),
    .s_valid(s_valid), .s_ready(s_ready),
    .s_addr(s_addr), .s_wstrb(s_wstrb),
    .s_wdata(s_wdata), .s_rdata(s_rdata),
    .fifo_rdata(fifo_rdata), .fifo_empty(fifo_empty),
    .fifo_pop(fifo_pop),
    .m_valid(m_valid), .m_ready(m_ready),
    .m_addr(m_addr), .m_wdata(m_wdata),
    .m_wstrb(m_wstrb), .irq(irq)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] fq[$];
  logic [31:0] popped[$];
  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];
  logic [31:0] exp_addr = '0;
  int exp_beats_left = 0;
  int exp_pops_left = 0;
  int beats = 0;
  int pops = 0;
  bit pop_now = 1'b0;
  bit stall_prev = 1'b0;
  bit rnd_rdy = 1'b0;
  logic [31:0] prev_addr = '0;
  logic [31:0] prev_data = '0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Per-cycle checker: pops, beats, stability, strobes.
  always @(negedge clk) begin
    pop_now = 1'b0;
    if (reset) begin
      stall_prev = 1'b0;
    end else begin
      chk("m_wstrb", 32'(m_wstrb), m_valid ? 32'hF : 32'h0);
      if (fifo_pop) begin
        chk("pop_allowed",
            32'(exp_pops_left != 0 && fq.size() != 0), 32'd1);
        if (exp_pops_left != 0 && fq.size() != 0) begin
          popped.push_back(fq[0]);
          exp_pops_left--;
          pops++;
          pop_now = 1'b1;
        end
      end
      if (m_valid && stall_prev) begin
        chk("addr_stable", m_addr, prev_addr);
        chk("data_stable", m_wdata, prev_data);
      end
      if (m_valid && m_ready) begin
        chk("beat_allowed",
            32'(exp_beats_left != 0 && popped.size() != 0), 32'd1);
        if (exp_beats_left != 0 && popped.size() != 0) begin
          chk("beat_addr", m_addr, exp_addr);
          chk("beat_data", m_wdata, popped.pop_front());
          log_addr.push_back(m_addr);
          log_data.push_back(m_wdata);
          exp_addr = exp_addr + 32'd4;
          exp_beats_left--;
          beats++;
        end
      end
      stall_prev = m_valid && !m_ready;
      prev_addr = m_addr;
      prev_data = m_wdata;
    end
  end

  // Show-ahead FIFO model driving the DUT.
  always @(posedge clk) begin
    logic [31:0] tmp;
    #1;
    if (pop_now && fq.size() != 0) tmp = fq.pop_front();
    #1;
    fifo_empty = (fq.size() == 0);
    fifo_rdata = (fq.size() == 0) ? 32'h0 : fq[0];
  end

  always @(posedge clk) begin
    if (rnd_rdy) begin
      #1;
      m_ready = ($urandom_range(0, 2) != 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [7:0] a, input logic [31:0] d);
    s_valid = 1'b1;
    s_addr = a;
    s_wstrb = 4'hF;
    s_wdata = d;
    tick();
    tick();
    s_valid = 1'b0;
    s_wstrb = 4'h0;
  endtask

  task automatic bus_rd(input logic [7:0] a, output logic [31:0] d);
    s_valid = 1'b1;
    s_addr = a;
    s_wstrb = 4'h0;
    tick();
    d = s_rdata;
    tick();
    s_valid = 1'b0;
  endtask

  task automatic rd_chk(input string nm, input logic [7:0] a,
                        input logic [31:0] exp);
    logic [31:0] d;
    bus_rd(a, d);
    chk(nm, d, exp);
  endtask

  task automatic wait_beats(input int n, input int lim);
    int c = 0;
    while (beats < n && c < lim) begin
      tick();
      c++;
    end
    chk("beats_reached", 32'(beats >= n), 32'd1);
  endtask

  task automatic wait_mvalid(input int lim);
    int c = 0;
    while (!m_valid && c < lim) begin
      tick();
      c++;
    end
    chk("m_valid_seen", 32'(m_valid), 32'd1);
  endtask

  task automatic start_xfer(input logic [31:0] dst, input int len,
                            input bit ien);
    bus_wr(8'h04, dst);
    bus_wr(8'h08, 32'(len));
    exp_addr = dst;
    exp_beats_left = len;
    exp_pops_left = len;
    bus_wr(8'h00, {30'd0, ien, 1'b1});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int b0;
    int p0;
    int lb;
    int len;
    int pre;
    bit ien;
    logic [31:0] dst;

    repeat (3) tick();
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    chk("rst_fifo_pop", 32'(fifo_pop), 32'd0);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_wstrb", 32'(m_wstrb), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_m_addr", m_addr, 32'd0);
    chk("rst_m_wdata", m_wdata, 32'd0);
    chk("rst_s_rdata", s_rdata, 32'd0);
    reset = 1'b0;
    tick();
    rd_chk("rst_status", 8'h0C, 32'd0);
    rd_chk("rst_count", 8'h10, 32'd0);
    rd_chk("rst_dst", 8'h04, 32'd0);
    rd_chk("rst_len", 8'h08, 32'd0);
    rd_chk("rst_ctrl", 8'h00, 32'd0);

    bus_wr(8'h04, 32'h0000_0103);
    rd_chk("dst_low_bits", 8'h04, 32'h0000_0100);
    bus_wr(8'h20, 32'hDEAD_BEEF);
    rd_chk("unmapped", 8'h20, 32'd0);

    // Basic three-word transfer.
    m_ready = 1'b1;
    b0 = beats;
    p0 = pops;
    lb = log_addr.size();
    fq.push_back(32'hA);
    fq.push_back(32'hB);
    fq.push_back(32'hC);
    start_xfer(32'h100, 3, 1'b0);
    wait_beats(b0 + 3, 100);
    repeat (3) tick();
    chk("t1_a0", log_addr[lb], 32'h100);
    chk("t1_d0", log_data[lb], 32'hA);
    chk("t1_a1", log_addr[lb+1], 32'h104);
    chk("t1_d1", log_data[lb+1], 32'hB);
    chk("t1_a2", log_addr[lb+2], 32'h108);
    chk("t1_d2", log_data[lb+2], 32'hC);
    chk("t1_pops", 32'(pops - p0), 32'd3);
    rd_chk("t1_count", 8'h10, 32'd3);
    rd_chk("t1_status", 8'h0C, 32'h2);

    // Zero-length start with interrupt enabled.
    bus_wr(8'h0C, 32'h6);
    b0 = beats;
    p0 = pops;
    start_xfer(32'h400, 0, 1'b1);
    tick();
    chk("len0_irq", 32'(irq), 32'd1);
    chk("len0_beats", 32'(beats - b0), 32'd0);
    chk("len0_pops", 32'(pops - p0), 32'd0);
    rd_chk("len0_status", 8'h0C, 32'h2);
    bus_wr(8'h0C, 32'h2);
    chk("len0_irq_clr", 32'(irq), 32'd0);
    rd_chk("len0_status_clr", 8'h0C, 32'h0);

    // Starved FIFO, then slow feed.
    b0 = beats;
    start_xfer(32'h800, 4, 1'b0);
    repeat (20) tick();
    chk("slow_no_pop", 32'(pops), 32'(p0));
    rd_chk("slow_busy0", 8'h0C, 32'h1);
    for (int i = 0; i < 4; i++) begin
      fq.push_back(32'h5000 + 32'(i));
      if (i == 2) begin
        wait_beats(b0 + 3, 50);
        rd_chk("slow_busy3", 8'h0C, 32'h1);
      end
      repeat (5) tick();
    end
    wait_beats(b0 + 4, 50);
    repeat (3) tick();
    rd_chk("slow_status", 8'h0C, 32'h2);
    bus_wr(8'h0C, 32'h6);

    // Stall beat 2, abort during the stall.
    b0 = beats;
    for (int i = 0; i < 4; i++) fq.push_back(32'h7700 + 32'(i));
    start_xfer(32'h200, 4, 1'b0);
    wait_beats(b0 + 1, 50);
    m_ready = 1'b0;
    wait_mvalid(20);
    repeat (5) tick();
    exp_pops_left = 0;
    exp_beats_left = 1;
    bus_wr(8'h00, 32'h4);
    m_ready = 1'b1;
    wait_beats(b0 + 2, 20);
    repeat (4) tick();
    rd_chk("abort_status", 8'h0C, 32'h4);
    rd_chk("abort_count", 8'h10, 32'd2);
    fq.delete();
    bus_wr(8'h0C, 32'h6);

    // Abort while waiting for data pops nothing.
    start_xfer(32'h300, 2, 1'b0);
    repeat (3) tick();
    exp_pops_left = 0;
    exp_beats_left = 0;
    bus_wr(8'h00, 32'h4);
    tick();
    rd_chk("abortw_status", 8'h0C, 32'h4);
    fq.push_back(32'h1234);
    repeat (5) tick();
    fq.delete();
    bus_wr(8'h0C, 32'h6);

    // Address wrap at the top of memory.
    b0 = beats;
    lb = log_addr.size();
    for (int i = 0; i < 3; i++) fq.push_back(32'hF00 + 32'(i));
    start_xfer(32'hFFFF_FFF8, 3, 1'b0);
    wait_beats(b0 + 3, 100);
    chk("wrap_a0", log_addr[lb], 32'hFFFF_FFF8);
    chk("wrap_a1", log_addr[lb+1], 32'hFFFF_FFFC);
    chk("wrap_a2", log_addr[lb+2], 32'h0000_0000);
    repeat (3) tick();
    bus_wr(8'h0C, 32'h6);

    // Second start while busy is ignored.
    b0 = beats;
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) fq.push_back(32'h9900 + 32'(i));
    start_xfer(32'h300, 4, 1'b0);
    wait_mvalid(20);
    bus_wr(8'h04, 32'h500);
    bus_wr(8'h08, 32'd9);
    bus_wr(8'h00, 32'h1);
    m_ready = 1'b1;
    wait_beats(b0 + 4, 100);
    repeat (4) tick();
    rd_chk("busy_start_status", 8'h0C, 32'h2);
    rd_chk("busy_start_count", 8'h10, 32'd4);
    rd_chk("busy_start_dst", 8'h04, 32'h500);
    bus_wr(8'h0C, 32'h6);

    // Reset in the middle of a stalled beat.
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) fq.push_back(32'h6600 + 32'(i));
    start_xfer(32'h600, 3, 1'b0);
    wait_mvalid(20);
    reset = 1'b1;
    tick();
    chk("rstmid_m_valid", 32'(m_valid), 32'd0);
    reset = 1'b0;
    popped.delete();
    fq.delete();
    exp_beats_left = 0;
    exp_pops_left = 0;
    m_ready = 1'b1;
    tick();
    rd_chk("rstmid_status", 8'h0C, 32'h0);
    rd_chk("rstmid_count", 8'h10, 32'd0);

    // Randomized transfers with random back-pressure and feed gaps.
    rnd_rdy = 1'b1;
    for (int t = 0; t < 12; t++) begin
      len = $urandom_range(1, 6);
      pre = $urandom_range(0, len);
      dst = $urandom & 32'hFFFF_FFFC;
      ien = 1'($urandom_range(0, 1));
      b0 = beats;
      for (int i = 0; i < pre; i++) fq.push_back($urandom);
      start_xfer(dst, len, ien);
      for (int i = pre; i < len; i++) begin
        repeat ($urandom_range(0, 4)) tick();
        fq.push_back($urandom);
      end
      wait_beats(b0 + len, 300);
      repeat (3) tick();
      chk("rnd_irq", 32'(irq), 32'(ien));
      rd_chk("rnd_status", 8'h0C, 32'h2);
      rd_chk("rnd_count", 8'h10, 32'(len));
      bus_wr(8'h0C, 32'h6);
      chk("rnd_irq_clr", 32'(irq), 32'd0);
    end
    rnd_rdy = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/accel_dma_ctrl.md
ACCEL_DMA_CTRL -- requirements
Module: accel_dma_ctrl

Interface
REQ-001 SHALL have parameter LEN_W, default 16: width of the transfer length and word-counter registers.
REQ-002 SHALL have port clk  input  1  single clock for all logic.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports s_valid/s_ready  input/output  1/1  CPU register-port handshake.
REQ-005 SHALL have ports s_addr  input  8  byte address; s_wstrb  input  4  write strobes (0 = read).
REQ-006 SHALL have ports s_wdata  input  32  write data; s_rdata  output  32  read data.
REQ-007 SHALL have ports fifo_rdata  input  32  result word, valid whenever fifo_empty=0 (show-ahead); fifo_empty  input  1.
REQ-008 SHALL have port fifo_pop  output  1  one-cycle pulse that consumes the word currently on fifo_rdata.
REQ-009 SHALL have ports m_valid/m_ready  output/input  1/1  write-master handshake toward SoC RAM.
REQ-010 SHALL have ports m_addr  output  32; m_wdata  output  32; m_wstrb  output  4  (4'hF while m_valid, else 0).
REQ-011 SHALL have port irq  output  1  level interrupt = done AND irq_en.

Function
REQ-012 SHALL decode registers: 0x00 CTRL (b0 start W1P, b1 irq_en RW, b2 abort W1P), 0x04 DST_ADDR (bits 1:0 read 0), 0x08 LEN (LEN_W bits, in words), 0x0C STATUS (b0 busy, b1 done W1C, b2 aborted W1C), 0x10 COUNT (read-only).
REQ-013 SHALL assert s_ready one cycle after s_valid, for exactly one cycle (s_ready <= s_valid && !s_ready), with s_rdata registered alongside; writes take effect on the s_ready cycle.
REQ-014 SHALL read unmapped offsets as 0 and ignore writes to them; byte-strobe granularity is not required, and any nonzero s_wstrb writes the full register.
REQ-015 SHALL implement FSM IDLE, WAIT_DATA, WRITE, FINISH.
REQ-016 IDLE: a start write with LEN!=0 loads the working address from DST_ADDR, clears COUNT, sets busy, and enters WAIT_DATA; a start write with LEN=0 goes directly to FINISH.
REQ-017 WAIT_DATA: while fifo_empty=0, pulse fifo_pop, latch fifo_rdata into the write buffer, and enter WRITE on the next cycle.
REQ-018 WRITE: hold m_valid, m_addr and m_wdata stable until m_ready; on m_ready, COUNT+=1 and address+=4 (32-bit wrap, 0xFFFFFFFC -> 0x00000000), then enter FINISH if COUNT equals LEN, else WAIT_DATA.
REQ-019 FINISH: set done, clear busy, and return to IDLE in one cycle.
REQ-020 SHALL ignore start writes while busy=1; DST_ADDR/LEN writes while busy SHALL update the registers but not affect the active transfer.
REQ-021 Abort in WAIT_DATA SHALL go to IDLE next cycle with aborted=1 and busy=0, popping nothing; abort in WRITE SHALL complete the pending beat first, then go to IDLE with aborted=1; done is not set on abort.
REQ-022 SHALL issue at most one fifo_pop per word, and never pop while fifo_empty=1 or outside WAIT_DATA.
REQ-023 Simultaneous start and abort in one write SHALL be treated as abort only (no transfer starts).
REQ-024 Minimum throughput: one word per 2 cycles plus the m_ready wait.

Reset
REQ-025 On reset: FSM=IDLE; all registers 0; outputs s_ready, fifo_pop, m_valid, m_wstrb, irq = 0; m_addr, m_wdata, s_rdata = 0.
REQ-026 Reset mid-transfer SHALL drop m_valid on the next edge without completing the beat; FIFO contents are not touched.

Structure
REQ-027 A shared package SHALL hold the register offset constants, the STATUS/CTRL bit indices, and the FSM state enum.
REQ-028 The block SHALL be a single module with the register file and FSM inline; no sub-module is required.

Verification
REQ-029 DST_ADDR=0x100, LEN=3, FIFO pre-loaded 0xA, 0xB, 0xC, m_ready=1 -> writes 0xA@0x100, 0xB@0x104, 0xC@0x108; COUNT=3, done=1, 3 pops.
REQ-030 LEN=0 start -> no m_valid, no pop; done=1 within 2 cycles; irq=1 when irq_en=1, cleared by a W1C of STATUS b1.
REQ-031 LEN=4, FIFO empty for 20 cycles then fed one word every 5 cycles -> no pop while empty; busy stays 1 until the 4th write completes.
REQ-032 m_ready held low 7 cycles during beat 2 -> m_addr/m_wdata stable throughout; abort issued then -> beat 2 completes, aborted=1, COUNT=2, done=0.
REQ-033 DST_ADDR=0xFFFFFFF8, LEN=3 -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
REQ-034 Start written while busy, and reset asserted mid-WRITE -> second start ignored; after reset, STATUS=0 and m_valid=0.
